// File: rtl/centroid_bank_writer_pkg.sv
// rtl/centroid_bank_writer_pkg.sv - shared k-means centroid bank geometry and writer state type
package kmeansTypes;
  localparam int NUM_BANK         = 8;
  localparam int NUM_BANK_BITS    = 3;
  localparam int NUM_CLUSTER_BITS = 3;
  localparam int MAX_DEPTH_BITS   = 9;
  localparam int CHUNK_IDX_BITS   = MAX_DEPTH_BITS - NUM_BANK_BITS;
  localparam int ADDR_BITS        = NUM_CLUSTER_BITS + CHUNK_IDX_BITS;
  localparam int DATA_BITS        = NUM_BANK * 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } cbw_state_t;
endpackage

// File: rtl/centroid_bank_writer_if.sv
// rtl/centroid_bank_writer_if.sv - centroid chunk stream in, bank write bus and load status out
interface cbw_if;
  import kmeansTypes::*;

  logic                        start;
  logic [NUM_CLUSTER_BITS:0]   num_cluster;
  logic [MAX_DEPTH_BITS:0]     data_dim;
  logic [DATA_BITS-1:0]        centroid_chunk;
  logic                        centroid_chunk_valid;
  logic                        last_chunk_of_one_centroid;
  logic                        last_chunk_of_all_centroid;
  logic [NUM_BANK-1:0]         bank_wr_en;
  logic [ADDR_BITS-1:0]        bank_wr_addr;
  logic [DATA_BITS-1:0]        bank_wr_data;
  logic                        centroids_loaded;
  logic                        load_done;
  logic                        load_busy;
  logic                        load_error;

  modport master (
    output start, num_cluster, data_dim, centroid_chunk, centroid_chunk_valid,
           last_chunk_of_one_centroid, last_chunk_of_all_centroid,
    input  bank_wr_en, bank_wr_addr, bank_wr_data, centroids_loaded,
           load_done, load_busy, load_error
  );

  modport slave (
    input  start, num_cluster, data_dim, centroid_chunk, centroid_chunk_valid,
           last_chunk_of_one_centroid, last_chunk_of_all_centroid,
    output bank_wr_en, bank_wr_addr, bank_wr_data, centroids_loaded,
           load_done, load_busy, load_error
  );
endinterface

// File: rtl/centroid_bank_writer_addr_gen.sv
// rtl/centroid_bank_writer_addr_gen.sv - cluster/chunk counters forming the shared bank address
module cbw_addr_gen
  import kmeansTypes::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 adv_i,
  input  logic                 last_one_i,
  output logic [ADDR_BITS-1:0] addr_o
);
  logic [NUM_CLUSTER_BITS-1:0] cluster_idx_q, cluster_idx_d;
  logic [CHUNK_IDX_BITS-1:0]   chunk_idx_q, chunk_idx_d;

  always_comb begin
    cluster_idx_d = cluster_idx_q;
    chunk_idx_d   = chunk_idx_q;
    if (clear_i) begin
      cluster_idx_d = '0;
      chunk_idx_d   = '0;
    end else if (adv_i) begin
      chunk_idx_d = chunk_idx_q + 1'b1;
      if (last_one_i) begin
        chunk_idx_d   = '0;
        cluster_idx_d = cluster_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cluster_idx_q <= '0;
      chunk_idx_q   <= '0;
    end else begin
      cluster_idx_q <= cluster_idx_d;
      chunk_idx_q   <= chunk_idx_d;
    end
  end

  assign addr_o = {cluster_idx_q, chunk_idx_q};
endmodule

// File: rtl/centroid_bank_writer.sv
// rtl/centroid_bank_writer.sv - scatters centroid chunk lanes into banks; KMEANS_CENTROID_CHECK_EN adds load_error
module centroid_bank_writer
  import kmeansTypes::*;
(
  input logic  clk,
  input logic  rst_n,
  cbw_if.slave bus
);
  cbw_state_t           state_q;
  logic [NUM_BANK-1:0]  wr_en_q;
  logic [ADDR_BITS-1:0] wr_addr_q;
  logic [DATA_BITS-1:0] wr_data_q;
  logic                 loaded_q;
  logic                 done_q;
  logic                 busy_q;
  logic [ADDR_BITS-1:0] addr;
  logic                 start_ok;
  logic                 chunk_in_load;

  // start is only honoured outside LOAD, and only then are the counters cleared
  assign start_ok      = bus.start && (state_q != LOAD);
  assign chunk_in_load = bus.centroid_chunk_valid && (state_q == LOAD);

  cbw_addr_gen u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (start_ok),
    .adv_i      (chunk_in_load),
    .last_one_i (bus.last_chunk_of_one_centroid),
    .addr_o     (addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      loaded_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      wr_en_q <= '0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            loaded_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          if (bus.centroid_chunk_valid) begin
            wr_en_q   <= '1;
            wr_addr_q <= addr;
            wr_data_q <= bus.centroid_chunk;
            if (bus.last_chunk_of_all_centroid) begin
              done_q   <= 1'b1;
              loaded_q <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bank_wr_en       = wr_en_q;
  assign bus.bank_wr_addr     = wr_addr_q;
  assign bus.bank_wr_data     = wr_data_q;
  assign bus.centroids_loaded = loaded_q;
  assign bus.load_done        = done_q;
  assign bus.load_busy        = busy_q;

`ifdef KMEANS_CENTROID_CHECK_EN
  logic [NUM_CLUSTER_BITS:0]   num_cluster_q;
  logic [MAX_DEPTH_BITS:0]     data_dim_q;
  logic                        err_q;
  logic [NUM_CLUSTER_BITS-1:0] cluster_idx;
  logic [CHUNK_IDX_BITS-1:0]   chunk_idx;
  logic [NUM_CLUSTER_BITS:0]   clusters_seen;
  logic [CHUNK_IDX_BITS:0]     chunks_seen;
  logic [MAX_DEPTH_BITS:0]     dim_seen;
  logic                        err_cond;

  assign cluster_idx   = addr[ADDR_BITS-1:CHUNK_IDX_BITS];
  assign chunk_idx     = addr[CHUNK_IDX_BITS-1:0];
  assign clusters_seen = {1'b0, cluster_idx} + 1'b1;
  assign chunks_seen   = {1'b0, chunk_idx} + 1'b1;
  assign dim_seen      = {chunks_seen, {NUM_BANK_BITS{1'b0}}};

  assign err_cond =
      (bus.centroid_chunk_valid && (state_q != LOAD)) ||
      (chunk_in_load && bus.last_chunk_of_all_centroid && (clusters_seen != num_cluster_q)) ||
      (chunk_in_load && bus.last_chunk_of_one_centroid && (dim_seen != data_dim_q)) ||
      (chunk_in_load && (&chunk_idx) && !bus.last_chunk_of_one_centroid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_cluster_q <= '0;
      data_dim_q    <= '0;
      err_q         <= 1'b0;
    end else if (start_ok) begin
      num_cluster_q <= bus.num_cluster;
      data_dim_q    <= bus.data_dim;
      err_q         <= 1'b0;
    end else if (err_cond) begin
      err_q <= 1'b1;
    end
  end

  assign bus.load_error = err_q;
`else
  assign bus.load_error = 1'b0;
`endif
endmodule
